// File: rtl/video_source_switch.sv
// Selects one of N_CH parallel video sources onto a registered output, switching on a
// vs edge of the current source (or at once), and blanking when that source stops producing vs.
//   state   | meaning
//   ST_RUN  | selected source live, no switch outstanding
//   ST_PEND | switch requested, waiting for a vs edge on the current source
//   ST_LOST | no vs edge seen for TIMEOUT_CYC cycles, outputs blanked
module video_source_switch #(
   parameter int   N_CH        = 4,
   parameter int   COLOR_W     = 12,
   parameter int   DEFAULT_CH  = 0,
   parameter int   SYNC_MODE   = 1,
   parameter logic VS_POL      = 1'b1,
   parameter int   TIMEOUT_CYC = 2_000_000,
   localparam int  SEL_W       = $clog2(N_CH),
   localparam int  CH_W        = 3 + 3*COLOR_W
) (
   input  logic                 sys_clk,
   input  logic                 reset_n,
   input  logic [N_CH*CH_W-1:0] src_bus,
   input  logic [SEL_W-1:0]     sel_req,
   input  logic                 sel_req_valid,
   output logic                 out_de,
   output logic                 out_hs,
   output logic                 out_vs,
   output logic [COLOR_W-1:0]   out_r,
   output logic [COLOR_W-1:0]   out_g,
   output logic [COLOR_W-1:0]   out_b,
   output logic [SEL_W-1:0]     cur_sel,
   output logic                 switch_done,
   output logic                 err_sel,
   output logic                 sig_lost
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_PEND = 2'd1;
   localparam logic [1:0] ST_LOST = 2'd2;

   localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_V  = TIMEOUT_CYC[CNT_W-1:0];
   localparam logic [CNT_W-1:0] TO_M1 = TO_V - 1'b1;
   localparam logic [SEL_W:0]   N_CH_V  = N_CH[SEL_W:0];
   localparam logic [SEL_W-1:0] DEF_SEL = DEFAULT_CH[SEL_W-1:0];
   localparam logic [CH_W-1:0]  BLANK   = {1'b0, ~VS_POL, ~VS_POL, {(3*COLOR_W){1'b0}}};

   logic [CH_W-1:0]  ch [N_CH];
   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
   logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vs_prev_q, vs_prev_d;
   logic [CH_W-1:0]  out_q, out_d;
   logic             switch_done_q, switch_done_d;
   logic             err_sel_q, err_sel_d;

   logic             req_in_range, req_ok, req_new, vs_edge, timeout, commit;
   logic [SEL_W-1:0] commit_sel;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign ch[k] = src_bus[k*CH_W +: CH_W];
   end

   assign req_in_range = ({1'b0, sel_req} < N_CH_V);
   assign req_ok       = sel_req_valid & req_in_range;
   assign req_new      = req_ok & (sel_req != cur_sel_q);
   assign vs_edge      = (ch[cur_sel_q][CH_W-3] == VS_POL) & (vs_prev_q != VS_POL);
   // Any in-range request, or a vs edge, holds off the watchdog for this cycle.
   assign timeout      = ~vs_edge & ~req_ok & (cnt_q >= TO_M1);

   always_comb begin
      state_d    = state_q;
      cur_sel_d  = cur_sel_q;
      pend_sel_d = pend_sel_q;
      commit     = 1'b0;
      commit_sel = cur_sel_q;
      err_sel_d  = sel_req_valid & ~req_in_range;
      case (state_q)
         ST_RUN: begin
            if (req_new) begin
               if (SYNC_MODE != 0) begin
                  state_d    = ST_PEND;
                  pend_sel_d = sel_req;
               end else begin
                  commit     = 1'b1;
                  commit_sel = sel_req;
               end
            end else if (timeout) begin
               state_d = ST_LOST;
            end
         end
         ST_PEND: begin
            if (vs_edge) begin
               commit     = 1'b1;
               commit_sel = pend_sel_q;
               if (req_ok && (sel_req != pend_sel_q)) pend_sel_d = sel_req;
               else                                    state_d    = ST_RUN;
            end else if (req_ok) begin
               pend_sel_d = sel_req;
               if (sel_req == cur_sel_q) state_d = ST_RUN;
            end else if (timeout) begin
               state_d    = ST_LOST;
               pend_sel_d = cur_sel_q;
            end
         end
         ST_LOST: begin
            if (req_new) begin
               commit     = 1'b1;
               commit_sel = sel_req;
               state_d    = ST_RUN;
            end else if (vs_edge) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (commit) cur_sel_d = commit_sel;
      switch_done_d = commit;
      if (vs_edge || commit) cnt_d = '0;
      else if (cnt_q == TO_V) cnt_d = cnt_q;
      else                    cnt_d = cnt_q + 1'b1;
      // After a commit the edge detector tracks the new source from its current level.
      vs_prev_d = ch[cur_sel_d][CH_W-3];
      out_d     = (state_d == ST_LOST) ? BLANK : ch[cur_sel_q];
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q       <= ST_RUN;
         cur_sel_q     <= DEF_SEL;
         pend_sel_q    <= DEF_SEL;
         cnt_q         <= '0;
         vs_prev_q     <= VS_POL;
         out_q         <= BLANK;
         switch_done_q <= 1'b0;
         err_sel_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_sel_q     <= cur_sel_d;
         pend_sel_q    <= pend_sel_d;
         cnt_q         <= cnt_d;
         vs_prev_q     <= vs_prev_d;
         out_q         <= out_d;
         switch_done_q <= switch_done_d;
         err_sel_q     <= err_sel_d;
      end
   end

   assign out_de      = out_q[CH_W-1];
   assign out_hs      = out_q[CH_W-2];
   assign out_vs      = out_q[CH_W-3];
   assign out_r       = out_q[3*COLOR_W-1:2*COLOR_W];
   assign out_g       = out_q[2*COLOR_W-1:COLOR_W];
   assign out_b       = out_q[COLOR_W-1:0];
   assign cur_sel     = cur_sel_q;
   assign switch_done = switch_done_q;
   assign err_sel     = err_sel_q;
   assign sig_lost    = (state_q == ST_LOST);

endmodule
